// File: rtl/mmio_counter_bank.sv
// Memory-mapped event-counter bank sitting between the CPU data port and L1.
// Accesses in the BASE_HI window hit local registers with a registered one-cycle response.
module mmio_counter_bank #(
    parameter int         NUM_CNT   = 8,
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] BASE_HI   = 8'hFF,
    parameter bit         SATURATE  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmem_read,
    input  logic               dmem_write,
    input  logic [15:0]        dmem_address,
    input  logic [15:0]        dmem_wdata,
    output logic               dmem_resp,
    output logic [15:0]        dmem_rdata,
    input  logic               l1_mem_resp,
    input  logic [15:0]        l1_mem_rdata,
    output logic               l1_mem_read,
    output logic               l1_mem_write,
    output logic [15:0]        l1_mem_address,
    output logic [15:0]        l1_mem_wdata,
    input  logic [NUM_CNT-1:0] cnt_event,
    output logic [NUM_CNT-1:0] cnt_overflow
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [6:0]           IDX_STATUS = 7'h7E;
    localparam logic [6:0]           IDX_CTRL   = 7'h7F;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t               state_q, state_d;
    logic                 resp_q, resp_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic                 enable_q, enable_d;

    logic                 sel;
    logic                 access;
    logic                 wr_en;
    logic                 clear_all;
    logic [6:0]           idx;
    logic [15:0]          reg_rdata;
    logic [NUM_CNT-1:0]   ovf_set;

    assign sel       = (dmem_address[15:8] == BASE_HI);
    assign idx       = dmem_address[7:1];
    assign access    = sel && (dmem_read || dmem_write) && (state_q == IDLE);
    assign wr_en     = access && dmem_write;
    assign clear_all = wr_en && (idx == IDX_CTRL) && dmem_wdata[1];

    // L1 sees the CPU request unchanged except that MMIO-window accesses are suppressed.
    assign l1_mem_read    = sel ? 1'b0 : dmem_read;
    assign l1_mem_write   = sel ? 1'b0 : dmem_write;
    assign l1_mem_address = dmem_address;
    assign l1_mem_wdata   = dmem_wdata;
    assign dmem_resp      = sel ? resp_q  : l1_mem_resp;
    assign dmem_rdata     = sel ? rdata_q : l1_mem_rdata;
    assign cnt_overflow   = ovf_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        reg_rdata = '0;
        if (idx == IDX_STATUS) begin
            reg_rdata = 16'(ovf_q);
        end else if (idx == IDX_CTRL) begin
            reg_rdata = {15'd0, enable_q};
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (idx == 7'(i)) reg_rdata = 16'(cnt_q[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        resp_d  = (state_d == RESP);
        rdata_d = access ? reg_rdata : rdata_q;
    end

    // Precedence: clear-all, then CPU counter write, then event increment; overflow set beats W1C.
    always_comb begin
        ovf_set  = '0;
        ovf_d    = ovf_q;
        enable_d = enable_q;
        for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = cnt_q[i];

        if (clear_all) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
            ovf_d    = '0;
            enable_d = dmem_wdata[0];
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (wr_en && (idx == 7'(i))) begin
                    cnt_d[i] = dmem_wdata[CNT_WIDTH-1:0];
                end else if (enable_q && cnt_event[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_set[i] = 1'b1;
                        cnt_d[i]   = SATURATE ? CNT_MAX : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
            if (wr_en && (idx == IDX_STATUS)) ovf_d = ovf_q & ~dmem_wdata[NUM_CNT-1:0];
            ovf_d = ovf_d | ovf_set;
            if (wr_en && (idx == IDX_CTRL)) enable_d = dmem_wdata[0];
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            ovf_q    <= '0;
            enable_q <= 1'b1;
            // NOTE: the counter array is plain flops, not a RAM, so every entry is reset.
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
